// File: rtl/e1_buf_wb_arb_if.sv
// e1_buf_wb_arb_if: N Wishbone master ports plus the one shared slave port, bundled.
// Latency: none (wires only).
// Backpressure: m_cyc is held until m_ack/m_err; s_cyc is held until s_ack.
interface e1_buf_wb_arb_if #(
  parameter int N  = 2,
  parameter int AW = 14,
  parameter int DW = 32
);
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_wdata;
  logic [N*DW/8-1:0] m_wmsk;
  logic [N-1:0]      m_we;
  logic [N-1:0]      m_cyc;
  logic [DW-1:0]     m_rdata;
  logic [N-1:0]      m_ack;
  logic [N-1:0]      m_err;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [DW/8-1:0]   s_wmsk;
  logic              s_we;
  logic              s_cyc;
  logic [DW-1:0]     s_rdata;
  logic              s_ack;
  logic [N-1:0]      grant;

  // Arbiter view: it masters the shared slave bus on behalf of the owner.
  modport master (
    input  m_addr, m_wdata, m_wmsk, m_we, m_cyc, s_rdata, s_ack,
    output m_rdata, m_ack, m_err, s_addr, s_wdata, s_wmsk, s_we, s_cyc, grant
  );

  // Environment view: the requesting masters and the buffer SRAM controller.
  modport slave (
    output m_addr, m_wdata, m_wmsk, m_we, m_cyc, s_rdata, s_ack,
    input  m_rdata, m_ack, m_err, s_addr, s_wdata, s_wmsk, s_we, s_cyc, grant
  );
endinterface

// File: rtl/e1_buf_wb_arb.sv
// e1_buf_wb_arb: round-robin arbiter sharing one Wishbone slave port (E1 buffer) among N masters.
// Latency: grant/s_cyc one cycle after m_cyc; one IDLE turnaround cycle after every transaction.
// Backpressure: single outstanding access; non-owners hold m_cyc until granted; watchdog cuts off a hung slave.
module e1_buf_wb_arb #(
  parameter int N   = 2,
  parameter int AW  = 14,
  parameter int DW  = 32,
  parameter int TMO = 15,
  parameter int CW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  e1_buf_wb_arb_if.master bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam bit WD_EN = (TMO != 0);
  localparam logic [CW-1:0] TMO_LAST = (TMO == 0) ? '0 : CW'(TMO - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] sel, sel_nxt;
  logic [SW-1:0] last, last_nxt;
  logic [SW-1:0] pick, idx;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  grant_q, grant_nxt;
  logic          found;
  logic          active, own_cyc, ack_ok, tmo_hit;

  assign active  = (state == ACTIVE);
  assign own_cyc = bus.m_cyc[sel];
  // s_ack only counts while s_cyc is actually driven.
  assign ack_ok  = active & own_cyc & bus.s_ack;
  // Ack wins over a simultaneous timeout.
  assign tmo_hit = WD_EN & active & own_cyc & ~bus.s_ack & (cnt == TMO_LAST);

  // Round-robin pick: first requester after the last-served index, with wrap.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = N; i >= 1; i--) begin
      idx = SW'((int'(last) + i) % N);
      if (bus.m_cyc[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state logic: grant in IDLE, finish on ack, abort or watchdog in ACTIVE.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    last_nxt  = last;
    cnt_nxt   = cnt;
    grant_nxt = grant_q;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = ACTIVE;
          sel_nxt   = pick;
          last_nxt  = pick;
          cnt_nxt   = '0;
          grant_nxt = N'(1) << pick;
        end
      end
      ACTIVE: begin
        if (ack_ok || !own_cyc || tmo_hit) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State register; last-served starts at N-1 so master 0 has first priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      last    <= SW'(N - 1);
      cnt     <= '0;
      grant_q <= '0;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      last    <= last_nxt;
      cnt     <= cnt_nxt;
      grant_q <= grant_nxt;
    end
  end

  // Slave mux and per-master strobes; slave fields are zero while IDLE.
  always_comb begin
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_wmsk  = '0;
    bus.s_we    = 1'b0;
    bus.s_cyc   = active & own_cyc;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    if (active) begin
      bus.s_addr  = bus.m_addr[sel*AW +: AW];
      bus.s_wdata = bus.m_wdata[sel*DW +: DW];
      bus.s_wmsk  = bus.m_wmsk[sel*(DW/8) +: DW/8];
      bus.s_we    = bus.m_we[sel];
    end
    for (int i = 0; i < N; i++) begin
      bus.m_ack[i] = ack_ok  & (sel == SW'(i));
      bus.m_err[i] = tmo_hit & (sel == SW'(i));
    end
  end

  assign bus.m_rdata = bus.s_rdata;
  assign bus.grant   = grant_q;
endmodule

// File: tb/tb_e1_buf_wb_arb.sv
// tb_e1_buf_wb_arb: directed scenarios plus randomized traffic against a round-robin reference model.
// Latency: inputs driven 1 ns after posedge, outputs sampled on negedge.
// Backpressure: slave responder acks slv_lat cycles after s_cyc rises (0 = never).
module tb_e1_buf_wb_arb;
  localparam int N = 2, AW = 14, DW = 32, TMO = 15, CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   slv_lat;

  e1_buf_wb_arb_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  e1_buf_wb_arb #(.N(N), .AW(AW), .DW(DW), .TMO(TMO), .CW(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    rd_fn = (a == 14'h0123) ? 32'h0123_4567 : (32'hC0DE_0000 ^ {18'd0, a} ^ {a, 18'd0});
  endfunction

  // Slave responder: counts s_cyc cycles and acks in cycle slv_lat+1.
  initial begin
    int scnt;
    logic want;
    logic [AW-1:0] a;
    scnt = 0;
    bus.s_ack = 1'b0;
    bus.s_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.s_cyc) scnt++; else scnt = 0;
      want = bus.s_cyc && (slv_lat != 0) && (scnt == slv_lat);
      a = bus.s_addr;
      @(posedge clk);
      #1;
      bus.s_ack = want;
      bus.s_rdata = want ? rd_fn(a) : DW'($urandom);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW/8-1:0] m, input logic we, input logic cyc);
    bus.m_addr[i*AW +: AW]         = a;
    bus.m_wdata[i*DW +: DW]        = d;
    bus.m_wmsk[i*(DW/8) +: DW/8]   = m;
    bus.m_we[i]                    = we;
    bus.m_cyc[i]                   = cyc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.m_addr = '0; bus.m_wdata = '0; bus.m_wmsk = '0; bus.m_we = '0; bus.m_cyc = '0;
    slv_lat = 1;
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.m_cyc = 2'b11;
    repeat (2) begin next_cycle(); @(negedge clk); end
    tests++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
    tests++; if (bus.s_cyc !== 1'b0) begin fails++; $display("FAIL reset_s_cyc: got %b want 0", bus.s_cyc); end
    tests++; if (bus.m_ack !== 2'b00) begin fails++; $display("FAIL reset_m_ack: got %b want 00", bus.m_ack); end
    tests++; if (bus.m_err !== 2'b00) begin fails++; $display("FAIL reset_m_err: got %b want 00", bus.m_err); end
    next_cycle(); rst_n = 1'b1; @(negedge clk);
    tests++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL reset_release_grant: got %b want 00", bus.grant); end
    next_cycle(); @(negedge clk);
    tests++; if (bus.grant !== 2'b01) begin fails++; $display("FAIL reset_first_priority: got %b want 01", bus.grant); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset(); slv_lat = 1;
    next_cycle(); set_master(0, 14'h0123, '0, '0, 1'b0, 1'b1); @(negedge clk);
    tests++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL single_c0_grant: got %b want 00", bus.grant); end
    next_cycle(); @(negedge clk);
    tests++; if (bus.grant !== 2'b01 || bus.s_cyc !== 1'b1) begin fails++; $display("FAIL single_c1_grant: got %b/%b want 01/1", bus.grant, bus.s_cyc); end
    tests++; if (bus.s_addr !== 14'h0123 || bus.s_we !== 1'b0) begin fails++; $display("FAIL single_c1_addr: got %h/%b want 0123/0", bus.s_addr, bus.s_we); end
    next_cycle(); @(negedge clk);
    tests++; if (bus.m_ack !== 2'b01) begin fails++; $display("FAIL single_c2_ack: got %b want 01", bus.m_ack); end
    tests++; if (bus.m_rdata !== 32'h0123_4567) begin fails++; $display("FAIL single_c2_rdata: got %h want 01234567", bus.m_rdata); end
    next_cycle(); bus.m_cyc[0] = 1'b0; @(negedge clk);
    tests++; if (bus.grant !== 2'b00 || bus.m_ack !== 2'b00) begin fails++; $display("FAIL single_c3_idle: got %b/%b want 00/00", bus.grant, bus.m_ack); end
  endtask

  task automatic test_contention();
    logic [1:0] seq [6];
    logic [1:0] pg;
    logic [1:0] ex;
    int n;
    n = 0; pg = '0;
    do_reset(); slv_lat = 1;
    next_cycle();
    set_master(0, 14'h0010, 32'h1111_0000, 4'hF, 1'b0, 1'b1);
    set_master(1, 14'h0020, 32'h2222_0000, 4'hF, 1'b0, 1'b1);
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (pg == 2'b00 && bus.grant != 2'b00) begin seq[n] = bus.grant; n++; end
      pg = bus.grant;
      next_cycle();
    end
    tests++; if (n != 6) begin fails++; $display("FAIL contention_count: got %0d grants want 6", n); end
    for (int k = 0; k < n; k++) begin
      ex = (k % 2 == 0) ? 2'b01 : 2'b10;
      tests++; if (seq[k] !== ex) begin fails++; $display("FAIL contention_seq%0d: got %b want %b", k, seq[k], ex); end
    end
  endtask

  task automatic test_write();
    do_reset(); slv_lat = 1;
    next_cycle(); set_master(1, 14'h3FFF, 32'hDEAD_BEEF, 4'b0101, 1'b1, 1'b1);
    @(negedge clk); next_cycle(); @(negedge clk);
    tests++; if (bus.grant !== 2'b10 || bus.s_we !== 1'b1) begin fails++; $display("FAIL write_grant_we: got %b/%b want 10/1", bus.grant, bus.s_we); end
    tests++; if (bus.s_addr !== 14'h3FFF || bus.s_wdata !== 32'hDEAD_BEEF || bus.s_wmsk !== 4'b0101) begin
      fails++; $display("FAIL write_fields: got %h/%h/%b want 3fff/deadbeef/0101", bus.s_addr, bus.s_wdata, bus.s_wmsk);
    end
    next_cycle(); @(negedge clk);
    tests++; if (bus.m_ack !== 2'b10) begin fails++; $display("FAIL write_ack: got %b want 10", bus.m_ack); end
    next_cycle(); bus.m_cyc[1] = 1'b0;
  endtask

  task automatic test_watchdog();
    int act, errs, acks0, err_at, err_c, g1_c;
    bit drop0;
    act = 0; errs = 0; acks0 = 0; err_at = -1; err_c = -1; g1_c = -1; drop0 = 0;
    do_reset(); slv_lat = 0;
    next_cycle(); set_master(0, 14'h0200, '0, '0, 1'b0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.grant == 2'b01 && bus.s_cyc) act++;
      if (bus.m_ack[0]) acks0++;
      if (bus.m_err[0]) begin errs++; err_at = act; err_c = c; drop0 = 1; end
      if (bus.grant == 2'b10 && g1_c < 0) g1_c = c;
      next_cycle();
      if (c == 0) set_master(1, 14'h0300, '0, '0, 1'b0, 1'b1);
      if (drop0) begin bus.m_cyc[0] = 1'b0; slv_lat = 1; drop0 = 0; end
    end
    tests++; if (act != TMO) begin fails++; $display("FAIL wdog_active_cycles: got %0d want %0d", act, TMO); end
    tests++; if (errs != 1 || err_at != TMO) begin fails++; $display("FAIL wdog_err_pulse: got %0d pulses at %0d want 1 at %0d", errs, err_at, TMO); end
    tests++; if (acks0 != 0) begin fails++; $display("FAIL wdog_no_ack: got %0d acks want 0", acks0); end
    tests++; if (g1_c != err_c + 2) begin fails++; $display("FAIL wdog_next_grant: got cycle %0d want %0d", g1_c, err_c + 2); end
  endtask

  task automatic test_tie();
    int act, acks, ack_at, errs;
    act = 0; acks = 0; ack_at = -1; errs = 0;
    do_reset(); slv_lat = TMO - 1;
    next_cycle(); set_master(0, 14'h0400, '0, '0, 1'b0, 1'b1);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.grant == 2'b01 && bus.s_cyc) act++;
      if (bus.m_err != 2'b00) errs++;
      if (bus.m_ack[0]) begin acks++; ack_at = act; end
      next_cycle();
      if (ack_at >= 0) bus.m_cyc[0] = 1'b0;
    end
    tests++; if (acks != 1 || ack_at != TMO) begin fails++; $display("FAIL tie_ack: got %0d acks at %0d want 1 at %0d", acks, ack_at, TMO); end
    tests++; if (errs != 0) begin fails++; $display("FAIL tie_no_err: got %0d err cycles want 0", errs); end
  endtask

  task automatic test_abort_reset();
    do_reset(); slv_lat = 0;
    next_cycle(); set_master(0, 14'h0500, '0, '0, 1'b0, 1'b1);
    repeat (3) begin @(negedge clk); next_cycle(); end
    bus.m_cyc[0] = 1'b0; @(negedge clk);
    tests++; if (bus.s_cyc !== 1'b0 || bus.m_ack !== 2'b00 || bus.m_err !== 2'b00) begin
      fails++; $display("FAIL abort_cycle: got s_cyc=%b ack=%b err=%b want 0/00/00", bus.s_cyc, bus.m_ack, bus.m_err);
    end
    next_cycle(); @(negedge clk);
    tests++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL abort_idle: got %b want 00", bus.grant); end
    next_cycle(); bus.m_cyc[0] = 1'b1; @(negedge clk);
    next_cycle(); @(negedge clk);
    tests++; if (bus.grant !== 2'b01) begin fails++; $display("FAIL abort_regrant: got %b want 01", bus.grant); end
    next_cycle(); set_master(1, 14'h0600, '0, '0, 1'b0, 1'b1); @(negedge clk);
    next_cycle(); rst_n = 1'b0; @(negedge clk);
    next_cycle(); @(negedge clk);
    tests++; if (bus.grant !== 2'b00 || bus.s_cyc !== 1'b0 || bus.m_ack !== 2'b00 || bus.m_err !== 2'b00) begin
      fails++; $display("FAIL midreset_outputs: got g=%b cyc=%b ack=%b err=%b want all 0", bus.grant, bus.s_cyc, bus.m_ack, bus.m_err);
    end
    next_cycle(); rst_n = 1'b1; @(negedge clk);
    next_cycle(); @(negedge clk);
    tests++; if (bus.grant !== 2'b01) begin fails++; $display("FAIL midreset_priority: got %b want 01", bus.grant); end
  endtask

  function automatic int pick_lat();
    case ($urandom_range(0, 6))
      0: pick_lat = 1;
      1: pick_lat = 2;
      2: pick_lat = 3;
      3: pick_lat = 6;
      4: pick_lat = 0;
      5: pick_lat = TMO - 1;
      default: pick_lat = TMO;
    endcase
  endfunction

  task automatic test_random();
    logic [N-1:0]    req, done, prev_req, pg, g, oh;
    logic [AW-1:0]   ma [N];
    logic [DW-1:0]   mw [N];
    logic [DW/8-1:0] mm [N];
    logic            mwe [N];
    int last_m, owner, ex, act, ndone, cyc, exp_act;
    bit was_done, exp_ack;
    req = '0; done = '0; prev_req = '0; pg = '0;
    last_m = N - 1; owner = 0; act = 0; ndone = 0; cyc = 0; was_done = 0;
    for (int i = 0; i < N; i++) begin ma[i] = '0; mw[i] = '0; mm[i] = '0; mwe[i] = 1'b0; end
    do_reset(); slv_lat = pick_lat();
    while (ndone < 40 && cyc < 3000) begin
      @(negedge clk); cyc++;
      g = bus.grant;
      if (was_done) begin
        tests++; if (g !== '0) begin fails++; $display("FAIL rnd_turnaround: got %b want 00", g); end
      end
      if (pg == '0 && g != '0) begin
        ex = -1;
        for (int k = 1; k <= N; k++) if (ex < 0 && prev_req[(last_m + k) % N]) ex = (last_m + k) % N;
        tests++;
        if (ex < 0 || g !== (N'(1) << ex)) begin fails++; $display("FAIL rnd_grant: got %b want master %0d", g, ex); end
        owner = (ex < 0) ? 0 : ex;
        last_m = owner; act = 0;
      end
      was_done = 0;
      if (g != '0) begin
        act++;
        oh = N'(1) << owner;
        tests++;
        if (bus.s_cyc !== 1'b1 || bus.s_addr !== ma[owner] || bus.s_wdata !== mw[owner] ||
            bus.s_wmsk !== mm[owner] || bus.s_we !== mwe[owner]) begin
          fails++; $display("FAIL rnd_slave_fields: got %h/%h/%b/%b want %h/%h/%b/%b", bus.s_addr, bus.s_wdata,
                            bus.s_wmsk, bus.s_we, ma[owner], mw[owner], mm[owner], mwe[owner]);
        end
        if (bus.m_ack != '0 || bus.m_err != '0) begin
          exp_ack = (slv_lat >= 1 && slv_lat <= TMO - 1);
          exp_act = exp_ack ? slv_lat + 1 : TMO;
          tests++; if (bus.m_ack !== (exp_ack ? oh : '0) || bus.m_err !== (exp_ack ? '0 : oh)) begin
            fails++; $display("FAIL rnd_outcome: got ack=%b err=%b want ack=%b err=%b", bus.m_ack, bus.m_err,
                              exp_ack ? oh : '0, exp_ack ? '0 : oh);
          end
          tests++; if (act != exp_act) begin fails++; $display("FAIL rnd_latency: got %0d want %0d", act, exp_act); end
          if (exp_ack) begin
            tests++; if (bus.m_rdata !== rd_fn(ma[owner])) begin fails++; $display("FAIL rnd_rdata: got %h want %h", bus.m_rdata, rd_fn(ma[owner])); end
          end
          done[owner] = 1'b1; was_done = 1; ndone++;
        end else if (act == TMO + 1) begin
          tests++; fails++; $display("FAIL rnd_hung: got %0d active cycles want at most %0d", act, TMO);
        end
      end else begin
        tests++;
        if (bus.s_cyc !== 1'b0 || bus.s_addr !== '0 || bus.m_ack !== '0 || bus.m_err !== '0) begin
          fails++; $display("FAIL rnd_idle: got cyc=%b addr=%h ack=%b err=%b want 0/0/0/0", bus.s_cyc, bus.s_addr, bus.m_ack, bus.m_err);
        end
      end
      pg = g; prev_req = req;
      next_cycle();
      if (was_done) slv_lat = pick_lat();
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          done[i] = 1'b0; req[i] = 1'b0; bus.m_cyc[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          ma[i] = AW'($urandom); mw[i] = DW'($urandom); mm[i] = 4'($urandom); mwe[i] = 1'($urandom);
          req[i] = 1'b1;
          set_master(i, ma[i], mw[i], mm[i], mwe[i], 1'b1);
        end
      end
    end
    tests++; if (ndone < 40) begin fails++; $display("FAIL rnd_progress: got %0d transactions want 40", ndone); end
  endtask

  initial begin
    rst_n = 1'b0;
    slv_lat = 1;
    bus.m_addr = '0; bus.m_wdata = '0; bus.m_wmsk = '0; bus.m_we = '0; bus.m_cyc = '0;
    test_reset();
    test_single();
    test_contention();
    test_write();
    test_watchdog();
    test_tie();
    test_abort_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
